// File: rtl/irq_controller.sv
// irq_controller: 4-source edge-triggered priority interrupt controller with context save/restore
module irq_controller (
  input  logic       clk,
  input  logic       StartEverything,
  input  logic [3:0] irq_in,
  input  logic       mask_we,
  input  logic [3:0] mask_din,
  input  logic       irq_ack,
  input  logic       reti,
  input  logic [7:0] ACCin,
  input  logic [2:0] flagsIn,
  output logic       irq_req,
  output logic [1:0] irq_vector,
  output logic       in_service,
  output logic [7:0] ACCsaved,
  output logic [2:0] flagsSaved,
  output logic       restore,
  output logic [3:0] pending
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t     st_q, st_d;
  logic [3:0] prev_q, pend_q, pend_d, mask_q, en, clr;
  logic       req_q, req_d, ins_q, ins_d, restore_q, restore_d;
  logic [1:0] vec_q, vec_d, lowest;
  logic [7:0] acc_q, acc_d;
  logic [2:0] flg_q, flg_d;
  assign en     = pend_q & mask_q;
  assign lowest = en[0] ? 2'd0 : en[1] ? 2'd1 : en[2] ? 2'd2 : 2'd3;
  // a new edge beats the acknowledge clear on the same bit
  assign pend_d = (pend_q & ~clr) | (irq_in & ~prev_q);
  always_comb begin
    st_d      = st_q;
    req_d     = req_q;
    vec_d     = vec_q;
    ins_d     = ins_q;
    restore_d = 1'b0;
    acc_d     = acc_q;
    flg_d     = flg_q;
    clr       = 4'b0;
    case (st_q)
      IDLE: if (|en) begin
        st_d  = REQ;
        req_d = 1'b1;
        vec_d = lowest;
      end
      REQ: if (irq_ack) begin
        st_d  = SERVICE;
        req_d = 1'b0;
        ins_d = 1'b1;
        acc_d = ACCin;
        flg_d = flagsIn;
        clr   = 4'b1 << vec_q;
      end
      SERVICE: if (reti) begin
        st_d      = IDLE;
        ins_d     = 1'b0;
        restore_d = 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (StartEverything) begin
      st_q      <= IDLE;
      prev_q    <= 4'b0;
      pend_q    <= 4'b0;
      mask_q    <= 4'b1111;
      req_q     <= 1'b0;
      vec_q     <= 2'd0;
      ins_q     <= 1'b0;
      restore_q <= 1'b0;
      acc_q     <= 8'b0;
      flg_q     <= 3'b0;
    end else begin
      st_q      <= st_d;
      prev_q    <= irq_in;
      pend_q    <= pend_d;
      mask_q    <= mask_we ? mask_din : mask_q;
      req_q     <= req_d;
      vec_q     <= vec_d;
      ins_q     <= ins_d;
      restore_q <= restore_d;
      acc_q     <= acc_d;
      flg_q     <= flg_d;
    end
  end
  assign irq_req    = req_q;
  assign irq_vector = vec_q;
  assign in_service = ins_q;
  assign ACCsaved   = acc_q;
  assign flagsSaved = flg_q;
  assign restore    = restore_q;
  assign pending    = pend_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed and random checks of irq_controller against a behavioural model
module tb_irq_controller;
  logic       clk = 1'b0;
  logic       rst, mwe, ack, rt;
  logic [3:0] irq, md;
  logic [7:0] acc;
  logic [2:0] fl;
  logic       irq_req, in_service, restore;
  logic [1:0] irq_vector;
  logic [7:0] ACCsaved;
  logic [2:0] flagsSaved;
  logic [3:0] pending;
  int total = 0, bad = 0;
  int m_mode, m_vec, m_pend, m_prev, m_mask, m_acc, m_fl;
  bit m_req, m_ins, m_rest;
  always #5 clk = ~clk;
  irq_controller dut (
    .clk(clk), .StartEverything(rst), .irq_in(irq), .mask_we(mwe), .mask_din(md),
    .irq_ack(ack), .reti(rt), .ACCin(acc), .flagsIn(fl), .irq_req(irq_req),
    .irq_vector(irq_vector), .in_service(in_service), .ACCsaved(ACCsaved),
    .flagsSaved(flagsSaved), .restore(restore), .pending(pending)
  );
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // mode: 0 waiting, 1 requesting, 2 handler running
  task automatic model();
    int en, clear, edges;
    if (rst) begin
      m_mode = 0; m_vec = 0; m_pend = 0; m_prev = 0; m_mask = 15;
      m_acc = 0; m_fl = 0; m_req = 0; m_ins = 0; m_rest = 0;
      return;
    end
    edges = irq & ~m_prev & 15;
    m_prev = irq;
    m_rest = 0;
    clear = 0;
    en = m_pend & m_mask;
    if (m_mode == 0 && en != 0) begin
      for (int i = 3; i >= 0; i--) if (en[i]) m_vec = i;
      m_req = 1; m_mode = 1;
    end else if (m_mode == 1 && ack) begin
      clear = 1 << m_vec;
      m_acc = acc; m_fl = fl; m_req = 0; m_ins = 1; m_mode = 2;
    end else if (m_mode == 2 && rt) begin
      m_ins = 0; m_rest = 1; m_mode = 0;
    end
    m_pend = ((m_pend & ~clear) | edges) & 15;
    if (mwe) m_mask = md;
  endtask
  task automatic cyc(input bit r, input logic [3:0] i, input bit w, input logic [3:0] d,
                     input bit a, input bit t, input logic [7:0] ac, input logic [2:0] f);
    rst = r; irq = i; mwe = w; md = d; ack = a; rt = t; acc = ac; fl = f;
    @(posedge clk);
    model();
    #1;
    chk("irq_req", irq_req, m_req);
    chk("in_service", in_service, m_ins);
    chk("restore", restore, m_rest);
    chk("pending", pending, m_pend);
    chk("ACCsaved", ACCsaved, m_acc);
    chk("flagsSaved", flagsSaved, m_fl);
    if (m_req) chk("irq_vector", irq_vector, m_vec);
  endtask
  task automatic idle(input logic [3:0] i);
    cyc(0, i, 0, 4'h0, 0, 0, 8'h00, 3'b000);
  endtask
  initial begin
    cyc(1, 4'h0, 0, 4'h0, 0, 0, 8'h00, 3'b000);
    cyc(1, 4'h0, 0, 4'h0, 0, 0, 8'h00, 3'b000);
    chk("rst_req", irq_req, 0); chk("rst_pend", pending, 0); chk("rst_ins", in_service, 0);
    // single source, context capture
    idle(4'b0100);
    chk("p32_pend", pending, 4'b0100); chk("p32_req0", irq_req, 0);
    idle(4'b0000);
    chk("p32_req", irq_req, 1); chk("p32_vec", irq_vector, 2);
    cyc(0, 4'h0, 0, 4'h0, 1, 0, 8'h5A, 3'b010);
    chk("p32_acc", ACCsaved, 8'h5A); chk("p32_fl", flagsSaved, 3'b010);
    chk("p32_ins", in_service, 1); chk("p32_pend0", pending, 0);
    cyc(0, 4'h0, 0, 4'h0, 0, 1, 8'h00, 3'b000);
    chk("p32_rest", restore, 1); chk("p32_ins0", in_service, 0);
    idle(4'h0);
    chk("p32_rest0", restore, 0);
    // priority
    idle(4'b1010);
    idle(4'b0000);
    chk("p33_vec", irq_vector, 1);
    cyc(0, 4'h0, 0, 4'h0, 1, 0, 8'h11, 3'b001);
    cyc(0, 4'h0, 0, 4'h0, 0, 1, 8'h00, 3'b000);
    idle(4'h0);
    chk("p33_req", irq_req, 1); chk("p33_vec3", irq_vector, 3);
    cyc(0, 4'h0, 0, 4'h0, 1, 0, 8'h22, 3'b100);
    chk("p33_pend", pending, 0);
    cyc(0, 4'h0, 0, 4'h0, 0, 1, 8'h00, 3'b000);
    // masking
    cyc(0, 4'h0, 1, 4'b1110, 0, 0, 8'h00, 3'b000);
    idle(4'b0001);
    idle(4'b0000);
    chk("p34_req0", irq_req, 0); chk("p34_pend", pending, 4'b0001);
    cyc(0, 4'h0, 1, 4'b1111, 0, 0, 8'h00, 3'b000);
    idle(4'h0);
    chk("p34_req", irq_req, 1); chk("p34_vec", irq_vector, 0);
    cyc(0, 4'h0, 0, 4'h0, 1, 0, 8'h00, 3'b000);
    // edge during service
    idle(4'b0001);
    idle(4'b0000);
    chk("p35_req0", irq_req, 0); chk("p35_pend", pending, 4'b0001);
    cyc(0, 4'h0, 0, 4'h0, 0, 1, 8'h00, 3'b000);
    chk("p35_rest", restore, 1); chk("p35_req1", irq_req, 0);
    idle(4'h0);
    chk("p35_req", irq_req, 1); chk("p35_vec", irq_vector, 0); chk("p35_rest0", restore, 0);
    cyc(0, 4'h0, 0, 4'h0, 1, 0, 8'h33, 3'b111);
    // reset during service
    cyc(1, 4'h0, 0, 4'h0, 0, 1, 8'h00, 3'b000);
    chk("p36_rest", restore, 0); chk("p36_ins", in_service, 0);
    chk("p36_acc", ACCsaved, 0); chk("p36_fl", flagsSaved, 0);
    // held line: one edge only
    for (int k = 0; k < 3; k++) idle(4'b0010);
    chk("p37_vec", irq_vector, 1);
    cyc(0, 4'b0010, 0, 4'h0, 1, 0, 8'h00, 3'b000);
    idle(4'b0010); idle(4'b0010);
    chk("p37_pend", pending, 0);
    cyc(0, 4'b0010, 0, 4'h0, 0, 1, 8'h00, 3'b000);
    // line high through reset
    cyc(1, 4'b1000, 0, 4'h0, 0, 0, 8'h00, 3'b000);
    idle(4'b1000);
    chk("p31_pend", pending, 4'b1000);
    for (int k = 0; k < 4000; k++)
      cyc($urandom_range(63) == 0, 4'($urandom), $urandom_range(7) == 0, 4'($urandom),
          $urandom_range(2) == 0, $urandom_range(2) == 0, 8'($urandom), 3'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: StartEverything  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-003 SHALL have port: irq_in  input  4  interrupt request lines, rising-edge triggered; bit 0 highest priority.
REQ-004 SHALL have port: mask_we  input  1  mask write strobe.
REQ-005 SHALL have port: mask_din  input  4  new mask value; 1 = source enabled.
REQ-006 SHALL have port: irq_ack  input  1  core acknowledge of current request.
REQ-007 SHALL have port: reti  input  1  core return-from-interrupt pulse.
REQ-008 SHALL have port: ACCin  input  8  core accumulator, captured as context.
REQ-009 SHALL have port: flagsIn  input  3  {overflow, zero, cout}, captured as context.
REQ-010 SHALL have port: irq_req  output  1  interrupt request to core (registered).
REQ-011 SHALL have port: irq_vector  output  2  index of requested source; valid while irq_req = 1.
REQ-012 SHALL have port: in_service  output  1  high while a handler is running.
REQ-013 SHALL have port: ACCsaved  output  8  context-saved accumulator.
REQ-014 SHALL have port: flagsSaved  output  3  context-saved flags.
REQ-015 SHALL have port: restore  output  1  one-cycle pulse telling core to reload ACCsaved/flagsSaved.
REQ-016 SHALL have port: pending  output  4  current pending register, for debug.

Function
REQ-017 Edge detect: prev register holds last irq_in; bit i edge = irq_in[i] & ~prev[i]; edge sets pending[i] on the same rising clk.
REQ-018 Mask register written from mask_din on any cycle with mask_we = 1; masking never clears pending bits.
REQ-019 FSM states IDLE, REQ, SERVICE.
REQ-020 IDLE: if (pending & mask) != 0 -> REQ; irq_vector latched to lowest-index set bit of (pending & mask); irq_req = 1 from that edge.
REQ-021 Latency: irq_in edge sampled at edge N -> pending at N -> irq_req high after edge N+1 (IDLE, no other activity).
REQ-022 REQ: irq_req and irq_vector held stable until irq_ack; mask writes or higher-priority edges never change the latched vector.
REQ-023 REQ with irq_ack = 1: clear pending[irq_vector], capture ACCin/flagsIn into ACCsaved/flagsSaved, irq_req <= 0, in_service <= 1, -> SERVICE.
REQ-024 Clear and new edge on same bit in same cycle: set wins (pending stays 1).
REQ-025 SERVICE: no nesting; edges keep accumulating in pending; irq_req stays 0.
REQ-026 SERVICE with reti = 1: in_service <= 0, restore = 1 for exactly one cycle, -> IDLE.
REQ-027 irq_ack outside REQ and reti outside SERVICE SHALL be ignored.
REQ-028 After return, a still-pending enabled source re-requests under REQ-020 (earliest: cycle after restore pulse).

Reset
REQ-029 StartEverything = 1 at a rising edge: state IDLE, pending 0, prev 0, mask 4'b1111, irq_req 0, irq_vector 0, in_service 0, restore 0, ACCsaved 0, flagsSaved 0.
REQ-030 Reset overrides all other inputs including mid-REQ or mid-SERVICE; no restore pulse generated.
REQ-031 An irq_in line held high through reset SHALL register one edge on the first cycle after reset (prev reset to 0).

Verification
REQ-032 Pulse irq_in[2] one cycle, mask 1111 -> irq_req = 1 two edges later, irq_vector = 2; ack with ACCin = 8'h5A, flagsIn = 3'b010 -> ACCsaved = 8'h5A, flagsSaved = 3'b010, in_service = 1.
REQ-033 Edges on irq_in[3] and irq_in[1] same cycle -> vector 1 first; after ack+reti, vector 3 requested; pending reaches 0.
REQ-034 mask = 1110, edge on irq_in[0] -> no irq_req, pending = 0001; write mask 1111 -> irq_req with vector 0.
REQ-035 Edge on irq_in[0] during SERVICE -> no irq_req until reti; restore pulses one cycle, then irq_req with vector 0.
REQ-036 Assert StartEverything during SERVICE -> next cycle all outputs at REQ-029 values, restore stays 0.
REQ-037 Hold irq_in[1] high continuously -> only one pending set; after ack, pending[1] stays 0.
